// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial frame transmitter: sync pattern, MSB-first payload, guard zeros
module seq_pattern_tx #(
  parameter int                DATA_W    = 8,
  parameter int                SYNC_W    = 3,
  parameter logic [SYNC_W-1:0] SYNC_PAT  = 3'b101,
  parameter int                GUARD_LEN = 2,
  parameter int                BAUD_DIV  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              abort,
  output logic              x_out,
  output logic              bit_strobe,
  output logic              tx_active,
  output logic              frame_done
);

  localparam int MAX_SD  = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int MAX_LEN = (MAX_SD > GUARD_LEN) ? MAX_SD : GUARD_LEN;
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int BAUD_W  = (BAUD_DIV > 1) ? $clog2(BAUD_DIV + 1) : 1;

  localparam logic [CNT_W-1:0]  LAST_SYNC  = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0]  LAST_DATA  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  LAST_GUARD = (GUARD_LEN > 0) ? CNT_W'(GUARD_LEN - 1) : '0;
  localparam logic [BAUD_W-1:0] LAST_BAUD  = BAUD_W'(BAUD_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SYNC  = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_GUARD = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [CNT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [SYNC_W-1:0] sync_q, sync_d;
  logic              x_out_q, x_out_d;
  logic              strobe_q, strobe_d;
  logic              done_q, done_d;
  logic              bit_end;

  assign in_ready   = (state_q == S_IDLE) && !abort;
  assign tx_active  = (state_q != S_IDLE);
  assign x_out      = x_out_q;
  assign bit_strobe = strobe_q;
  assign frame_done = done_q;
  assign bit_end    = (baud_q == LAST_BAUD);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    sync_d   = sync_q;
    x_out_d  = x_out_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    if (state_q != S_IDLE && abort) begin
      state_d = S_IDLE;
      baud_d  = '0;
      bit_d   = '0;
      shift_d = '0;
      sync_d  = '0;
      x_out_d = 1'b0;
    end else if (state_q == S_IDLE) begin
      x_out_d = 1'b0;
      if (in_valid && in_ready) begin
        state_d  = S_SYNC;
        shift_d  = in_data;
        sync_d   = SYNC_PAT;
        x_out_d  = SYNC_PAT[SYNC_W-1];
        strobe_d = 1'b1;
        baud_d   = '0;
        bit_d    = '0;
      end
    end else if (!bit_end) begin
      baud_d = baud_q + 1'b1;
    end else begin
      // Bit boundary: the next bit value is registered so x_out changes exactly on this edge.
      baud_d   = '0;
      strobe_d = 1'b1;
      case (state_q)
        S_SYNC: begin
          if (bit_q == LAST_SYNC) begin
            state_d = S_DATA;
            bit_d   = '0;
            x_out_d = shift_q[DATA_W-1];
          end else begin
            bit_d   = bit_q + 1'b1;
            sync_d  = sync_q << 1;
            x_out_d = sync_d[SYNC_W-1];
          end
        end
        S_DATA: begin
          if (bit_q != LAST_DATA) begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q << 1;
            x_out_d = shift_d[DATA_W-1];
          end else if (GUARD_LEN > 0) begin
            state_d = S_GUARD;
            bit_d   = '0;
            x_out_d = 1'b0;
          end else begin
            state_d  = S_IDLE;
            bit_d    = '0;
            x_out_d  = 1'b0;
            strobe_d = 1'b0;
            done_d   = 1'b1;
          end
        end
        default: begin
          x_out_d = 1'b0;
          if (bit_q == LAST_GUARD) begin
            state_d  = S_IDLE;
            bit_d    = '0;
            strobe_d = 1'b0;
            done_d   = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      sync_q   <= '0;
      x_out_q  <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      sync_q   <= sync_d;
      x_out_q  <= x_out_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - scoreboard bench for seq_pattern_tx
module tb_seq_pattern_tx;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       abort;
  logic [2:0] vld, rdy, xo, stb, act, done;
  int         n_vec = 0;
  int         n_err = 0;
  logic       exp_q[$];

  always #5 clk = ~clk;

  // Instance 0: defaults; 1: BAUD_DIV=4; 2: GUARD_LEN=0
  seq_pattern_tx u_def (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(vld[0]), .in_ready(rdy[0]),
    .abort(abort), .x_out(xo[0]), .bit_strobe(stb[0]), .tx_active(act[0]), .frame_done(done[0]));
  seq_pattern_tx #(.BAUD_DIV(4)) u_b4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(vld[1]), .in_ready(rdy[1]),
    .abort(abort), .x_out(xo[1]), .bit_strobe(stb[1]), .tx_active(act[1]), .frame_done(done[1]));
  seq_pattern_tx #(.GUARD_LEN(0)) u_g0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(vld[2]), .in_ready(rdy[2]),
    .abort(abort), .x_out(xo[2]), .bit_strobe(stb[2]), .tx_active(act[2]), .frame_done(done[2]));

  function automatic void push_frame(input logic [7:0] d, input int guard);
    logic [2:0] sp = 3'b101;
    for (int i = 2; i >= 0; i--) exp_q.push_back(sp[i]);
    for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
    for (int i = 0; i < guard; i++) exp_q.push_back(1'b0);
  endfunction

  task automatic test_reset;
    logic [4:0] st;
    rst = 1'b1; vld = '0; abort = 1'b0; in_data = '0;
    #1;
    st = {xo[0], rdy[0], act[0], done[0], stb[0]};
    n_vec++;
    if (st !== 5'b01000) begin n_err++; $display("FAIL reset_init got %b exp 01000", st); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    in_data = 8'hA5; vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    n_vec++;
    if (xo[0] !== 1'b1) begin n_err++; $display("FAIL reset_pre_sync got %b exp 1", xo[0]); end
    #2 rst = 1'b1;
    #1;
    st = {xo[0], rdy[0], act[0], done[0], stb[0]};
    n_vec++;
    if (st !== 5'b01000) begin n_err++; $display("FAIL reset_async got %b exp 01000", st); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      st = {xo[0], rdy[0], act[0], done[0], stb[0]};
      n_vec++;
      if (st !== 5'b01000) begin n_err++; $display("FAIL reset_hold i%0d got %b exp 01000", i, st); end
    end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      st = {2'b00, xo[0], act[0], done[0]};
      n_vec++;
      if (st !== 5'b00000) begin n_err++; $display("FAIL reset_lost_frame i%0d got %b exp 00000", i, st); end
    end
  endtask

  task automatic test_basic;
    logic [3:0] st, ex;
    logic       e;
    exp_q.delete();
    @(negedge clk);
    n_vec++;
    if (rdy[0] !== 1'b1) begin n_err++; $display("FAIL basic_ready_idle got %b exp 1", rdy[0]); end
    in_data = 8'hA5; vld[0] = 1'b1;
    push_frame(8'hA5, 2);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      st = {stb[0], act[0], rdy[0], done[0]};
      ex = (c <= 13) ? 4'b1100 : (c == 14) ? 4'b0011 : 4'b0010;
      n_vec++;
      if (st !== ex) begin n_err++; $display("FAIL basic_status cyc%0d got %b exp %b", c, st, ex); end
      if (stb[0]) begin
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL basic_extra_bit cyc%0d got %b exp none", c, xo[0]); end
        else begin
          e = exp_q.pop_front();
          if (xo[0] !== e) begin n_err++; $display("FAIL basic_bit cyc%0d got %b exp %b", c, xo[0], e); end
        end
      end
      if (c >= 14) begin
        n_vec++;
        if (xo[0] !== 1'b0) begin n_err++; $display("FAIL basic_idle_x cyc%0d got %b exp 0", c, xo[0]); end
      end
      if (c == 1) begin vld[0] = 1'b0; in_data = 8'hFF; end
    end
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL basic_drain got %0d bits left exp 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] st, ex;
    logic       e, idle;
    exp_q.delete();
    @(negedge clk);
    in_data = 8'h3C; vld[0] = 1'b1;
    push_frame(8'h3C, 2);
    for (int c = 1; c <= 29; c++) begin
      @(negedge clk);
      idle = (c == 14) || (c >= 28);
      st = {stb[0], act[0], rdy[0], done[0]};
      ex = {!idle, !idle, idle, (c == 14) || (c == 28)};
      n_vec++;
      if (st !== ex) begin n_err++; $display("FAIL b2b_status cyc%0d got %b exp %b", c, st, ex); end
      if (stb[0]) begin
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL b2b_extra_bit cyc%0d got %b exp none", c, xo[0]); end
        else begin
          e = exp_q.pop_front();
          if (xo[0] !== e) begin n_err++; $display("FAIL b2b_bit cyc%0d got %b exp %b", c, xo[0], e); end
        end
      end
      if (c == 14) begin
        n_vec++;
        if (xo[0] !== 1'b0) begin n_err++; $display("FAIL b2b_gap cyc%0d got %b exp 0", c, xo[0]); end
        push_frame(8'hC3, 2);
      end
      if (c == 15) begin
        n_vec++;
        if (xo[0] !== 1'b1) begin n_err++; $display("FAIL b2b_second_sync got %b exp 1", xo[0]); end
        vld[0] = 1'b0;
      end
      if (c == 1) in_data = 8'hC3;
    end
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_drain got %0d bits left exp 0", exp_q.size()); end
  endtask

  task automatic test_baud4;
    logic [3:0] st, ex;
    logic       cur;
    int         n_stb, n_done;
    exp_q.delete();
    n_stb = 0; n_done = 0; cur = 1'b0;
    @(negedge clk);
    in_data = 8'hFF; vld[1] = 1'b1;
    push_frame(8'hFF, 2);
    for (int c = 1; c <= 56; c++) begin
      @(negedge clk);
      if (c == 1) vld[1] = 1'b0;
      st = {stb[1], act[1], rdy[1], done[1]};
      ex = {(c <= 52) && ((c - 1) % 4 == 0), c <= 52, c > 52, c == 53};
      n_vec++;
      if (st !== ex) begin n_err++; $display("FAIL baud4_status cyc%0d got %b exp %b", c, st, ex); end
      if (stb[1]) begin
        n_stb++;
        if (exp_q.size() != 0) cur = exp_q.pop_front();
      end
      if (done[1]) n_done++;
      if (c <= 52) begin
        n_vec++;
        if (xo[1] !== cur) begin n_err++; $display("FAIL baud4_hold cyc%0d got %b exp %b", c, xo[1], cur); end
      end
    end
    n_vec++;
    if (n_stb != 13) begin n_err++; $display("FAIL baud4_strobes got %0d exp 13", n_stb); end
    n_vec++;
    if (n_done != 1) begin n_err++; $display("FAIL baud4_done_count got %0d exp 1", n_done); end
  endtask

  task automatic test_abort;
    logic [3:0] st, ex;
    logic [4:0] s5;
    logic       e;
    exp_q.delete();
    @(negedge clk);
    in_data = 8'h5A; vld[0] = 1'b1;
    push_frame(8'h5A, 2);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) vld[0] = 1'b0;
      st = {stb[0], act[0], rdy[0], done[0]};
      n_vec++;
      if (st !== 4'b1100) begin n_err++; $display("FAIL abort_pre cyc%0d got %b exp 1100", c, st); end
      if (stb[0] && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (xo[0] !== e) begin n_err++; $display("FAIL abort_bit cyc%0d got %b exp %b", c, xo[0], e); end
      end
    end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    s5 = {xo[0], act[0], rdy[0], done[0], stb[0]};
    n_vec++;
    if (s5 !== 5'b00100) begin n_err++; $display("FAIL abort_idle got %b exp 00100", s5); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if ({act[0], done[0]} !== 2'b00) begin n_err++; $display("FAIL abort_no_done i%0d got %b exp 00", i, {act[0], done[0]}); end
    end
    abort = 1'b1; in_data = 8'h81; vld[0] = 1'b1;
    #1;
    n_vec++;
    if (rdy[0] !== 1'b0) begin n_err++; $display("FAIL abort_idle_block got %b exp 0", rdy[0]); end
    @(negedge clk);
    n_vec++;
    if (act[0] !== 1'b0) begin n_err++; $display("FAIL abort_idle_noaccept got %b exp 0", act[0]); end
    abort = 1'b0;
    push_frame(8'h81, 2);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) vld[0] = 1'b0;
      st = {stb[0], act[0], rdy[0], done[0]};
      ex = (c <= 13) ? 4'b1100 : 4'b0011;
      n_vec++;
      if (st !== ex) begin n_err++; $display("FAIL abort_refr_status cyc%0d got %b exp %b", c, st, ex); end
      if (stb[0]) begin
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL abort_refr_extra cyc%0d got %b exp none", c, xo[0]); end
        else begin
          e = exp_q.pop_front();
          if (xo[0] !== e) begin n_err++; $display("FAIL abort_refr_bit cyc%0d got %b exp %b", c, xo[0], e); end
        end
      end
    end
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL abort_drain got %0d bits left exp 0", exp_q.size()); end
  endtask

  task automatic test_guard0;
    logic [3:0] st, ex;
    logic       e;
    exp_q.delete();
    @(negedge clk);
    in_data = 8'h01; vld[2] = 1'b1;
    push_frame(8'h01, 0);
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (c == 1) vld[2] = 1'b0;
      st = {stb[2], act[2], rdy[2], done[2]};
      ex = (c <= 11) ? 4'b1100 : (c == 12) ? 4'b0011 : 4'b0010;
      n_vec++;
      if (st !== ex) begin n_err++; $display("FAIL guard0_status cyc%0d got %b exp %b", c, st, ex); end
      if (stb[2]) begin
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL guard0_extra cyc%0d got %b exp none", c, xo[2]); end
        else begin
          e = exp_q.pop_front();
          if (xo[2] !== e) begin n_err++; $display("FAIL guard0_bit cyc%0d got %b exp %b", c, xo[2], e); end
        end
      end
      if (c >= 12) begin
        n_vec++;
        if (xo[2] !== 1'b0) begin n_err++; $display("FAIL guard0_idle_x cyc%0d got %b exp 0", c, xo[2]); end
      end
    end
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL guard0_drain got %0d bits left exp 0", exp_q.size()); end
  endtask

  initial begin
    vld = '0; abort = 1'b0; in_data = '0; rst = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_baud4();
    test_abort();
    test_guard0();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
